// File: rtl/card_dealer_stage_pkg.sv
// ----------------------------------------------------------------------------
// card_dealer_stage_pkg
// Shared constants, FSM state type and card-validity helper for the card
// dealer stage and its output FIFO.
// ----------------------------------------------------------------------------
package card_dealer_stage_pkg;

    localparam int unsigned CARD_W    = 8;
    localparam int unsigned DECK_SIZE = 52;
    localparam int unsigned CNT_W     = 6;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait,
        StCheck
    } dealer_state_e;

    // A code from the generator names a real card only if it is below 52.
    function automatic logic is_valid_card(input logic [CARD_W-1:0] card);
        return 32'(card) < DECK_SIZE;
    endfunction

endpackage

// File: rtl/card_fifo.sv
// ----------------------------------------------------------------------------
// card_fifo
// Small synchronous FIFO buffering accepted cards. Head is read straight from
// the storage array; flush drops all entries.
// Ports:
//   clk_i, rst_i : clock, synchronous active-high reset
//   flush_i      : empty the FIFO (wins over push/pop)
//   push_i/din_i : write an entry
//   pop_i        : drop the head entry (ignored when empty)
//   dout_o       : head entry
//   empty_o      : no entries held
//   count_o      : current occupancy
// ----------------------------------------------------------------------------
module card_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         din_i,
    output logic [WIDTH-1:0]         dout_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [PTR_W:0]   r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push  = push_i && (r_count != FULL_CNT);
    assign w_pop   = pop_i && (r_count != '0);
    assign dout_o  = r_mem[r_rptr];
    assign empty_o = (r_count == '0);
    assign count_o = r_count;

    // Depth is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (flush_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= din_i;
                r_wptr        <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/card_dealer_stage.sv
// ----------------------------------------------------------------------------
// card_dealer_stage
// Requests cards from the random card generator, samples the response a fixed
// latency later, rejects out-of-range or already-dealt codes (re-requesting
// back to back), tracks the 52-card deck and buffers accepted cards in a FIFO.
// Ports:
//   clk_i, rst_i            : clock, synchronous active-high reset
//   enable_i                : dealing permitted while high
//   shuffle_i               : pulse, start a new deck (applied when idle)
//   card_i                  : generator response code
//   request_card_o          : one-cycle request pulse to the generator
//   card_o/card_valid_o     : FIFO head and non-empty flag
//   card_ready_i            : consumer takes head when valid & ready
//   dealt_cnt_o             : cards accepted since last shuffle
//   deck_empty_o            : all 52 cards dealt
//   stall_err_o             : sticky, too many consecutive rejects
// ----------------------------------------------------------------------------
module card_dealer_stage
    import card_dealer_stage_pkg::*;
#(
    parameter int unsigned RESP_LAT   = 2,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned MAX_RETRY  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              enable_i,
    input  logic              shuffle_i,
    input  logic [CARD_W-1:0] card_i,
    output logic              request_card_o,
    output logic [CARD_W-1:0] card_o,
    output logic              card_valid_o,
    input  logic              card_ready_i,
    output logic [CNT_W-1:0]  dealt_cnt_o,
    output logic              deck_empty_o,
    output logic              stall_err_o
);

    localparam int unsigned OCC_W = $clog2(FIFO_DEPTH) + 1;

    dealer_state_e          r_state;
    logic [2:0]             r_wait;
    logic [7:0]             r_retry;
    logic [DECK_SIZE-1:0]   r_mask;
    logic [CNT_W-1:0]       r_dealt;
    logic                   r_stall;
    logic                   r_req;
    logic                   r_shuf_pend;

    logic [OCC_W-1:0]       w_occ;
    logic                   w_fifo_empty;
    logic [5:0]             w_idx;
    logic                   w_accept;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_flush;
    logic                   w_can_req;

    assign w_idx    = card_i[5:0];
    // The mask is only consulted once the code is known to be in range.
    assign w_accept = is_valid_card(card_i) && !r_mask[w_idx];
    assign w_push   = (r_state == StCheck) && w_accept;
    assign w_flush  = (r_state == StIdle) && r_shuf_pend;
    assign w_pop    = card_valid_o && card_ready_i;

    assign deck_empty_o   = (r_dealt == CNT_W'(DECK_SIZE));
    assign w_can_req      = enable_i && !r_stall && !deck_empty_o && (32'(w_occ) < FIFO_DEPTH);
    assign request_card_o = r_req;
    assign dealt_cnt_o    = r_dealt;
    assign stall_err_o    = r_stall;
    assign card_valid_o   = !w_fifo_empty;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= StIdle;
            r_wait      <= '0;
            r_retry     <= '0;
            r_mask      <= '0;
            r_dealt     <= '0;
            r_stall     <= 1'b0;
            r_req       <= 1'b0;
            r_shuf_pend <= 1'b0;
        end else begin
            r_req <= 1'b0;
            if (shuffle_i) begin
                r_shuf_pend <= 1'b1;
            end
            case (r_state)
                StIdle: begin
                    // A pending shuffle takes the whole idle cycle; any pulse
                    // arriving now is absorbed into it.
                    if (r_shuf_pend) begin
                        r_mask      <= '0;
                        r_dealt     <= '0;
                        r_stall     <= 1'b0;
                        r_retry     <= '0;
                        r_shuf_pend <= 1'b0;
                    end else if (w_can_req) begin
                        r_state <= StReq;
                        r_req   <= 1'b1;
                    end
                end
                StReq: begin
                    r_wait  <= 3'(RESP_LAT - 1);
                    r_state <= (RESP_LAT == 1) ? StCheck : StWait;
                end
                StWait: begin
                    r_wait <= r_wait - 1'b1;
                    if (r_wait == 3'd1) begin
                        r_state <= StCheck;
                    end
                end
                StCheck: begin
                    if (w_accept) begin
                        r_mask[w_idx] <= 1'b1;
                        r_dealt       <= r_dealt + 1'b1;
                        r_retry       <= '0;
                        r_state       <= StIdle;
                    end else if (32'(r_retry) + 32'd1 >= MAX_RETRY) begin
                        r_stall <= 1'b1;
                        r_retry <= '0;
                        r_state <= StIdle;
                    end else begin
                        r_retry <= r_retry + 1'b1;
                        r_state <= StReq;
                        r_req   <= 1'b1;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    card_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (CARD_W)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (w_flush),
        .push_i  (w_push),
        .pop_i   (w_pop),
        .din_i   (card_i),
        .dout_o  (card_o),
        .empty_o (w_fifo_empty),
        .count_o (w_occ)
    );

endmodule

// File: tb/tb_card_dealer_stage.sv
// ----------------------------------------------------------------------------
// tb_card_dealer_stage
// Drives the dealer with directed and random traffic, plays the generator role
// (response on card_i exactly RESP_LAT cycles after each request, junk
// otherwise) and compares every cycle against a transaction/timestamp model
// of the dealing rules.
// ----------------------------------------------------------------------------
module tb_card_dealer_stage;

    localparam int unsigned RESP_LAT   = 2;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned MAX_RETRY  = 16;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       enable_i;
    logic       shuffle_i;
    logic [7:0] card_i;
    logic       request_card_o;
    logic [7:0] card_o;
    logic       card_valid_o;
    logic       card_ready_i;
    logic [5:0] dealt_cnt_o;
    logic       deck_empty_o;
    logic       stall_err_o;

    always #5 clk_i = ~clk_i;

    card_dealer_stage #(
        .RESP_LAT   (RESP_LAT),
        .FIFO_DEPTH (FIFO_DEPTH),
        .MAX_RETRY  (MAX_RETRY)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .enable_i       (enable_i),
        .shuffle_i      (shuffle_i),
        .card_i         (card_i),
        .request_card_o (request_card_o),
        .card_o         (card_o),
        .card_valid_o   (card_valid_o),
        .card_ready_i   (card_ready_i),
        .dealt_cnt_o    (dealt_cnt_o),
        .deck_empty_o   (deck_empty_o),
        .stall_err_o    (stall_err_o)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: deck contents, expected FIFO contents, counters, and
    // the cycle stamp of the outstanding request.
    bit m_deck [52];
    int m_fifo [$];
    int m_dealt;
    bit m_stall;
    int m_retry;
    bit m_pend;
    bit m_busy;
    int m_req_cyc;
    int cyc;
    int n_req = 0;
    int resp_q [$];

    task automatic model_reset();
        for (int i = 0; i < 52; i++) m_deck[i] = 1'b0;
        m_fifo.delete();
        m_dealt   = 0;
        m_stall   = 1'b0;
        m_retry   = 0;
        m_pend    = 1'b0;
        m_busy    = 1'b0;
        m_req_cyc = -100;
        cyc       = 0;
    endtask

    function automatic int next_card();
        int r;
        int free_q [$];
        if (resp_q.size() != 0) return resp_q.pop_front();
        r = int'($urandom_range(0, 9));
        if (r < 7) begin
            for (int i = 0; i < 52; i++) if (!m_deck[i]) free_q.push_back(i);
            if (free_q.size() != 0) return free_q[$urandom_range(0, free_q.size() - 1)];
        end
        if (r < 9) return int'($urandom_range(52, 255));
        return int'($urandom_range(0, 51));
    endfunction

    // Called mid-cycle (just after a negedge): check this cycle's outputs,
    // drive card_i, advance the model with this cycle's inputs, then move on
    // to the next cycle's negedge.
    task automatic step();
        int  occ;
        int  card;
        bit  at_check;
        bit  idle_apply;
        check_eq("request_card_o", 32'(request_card_o), 32'(m_busy && (cyc == m_req_cyc)));
        check_eq("card_valid_o", 32'(card_valid_o), 32'(m_fifo.size() != 0));
        if (m_fifo.size() != 0) check_eq("card_o", 32'(card_o), 32'(m_fifo[0]));
        check_eq("dealt_cnt_o", 32'(dealt_cnt_o), 32'(m_dealt));
        check_eq("deck_empty_o", 32'(deck_empty_o), 32'(m_dealt == 52));
        check_eq("stall_err_o", 32'(stall_err_o), 32'(m_stall));
        if (request_card_o === 1'b1) n_req++;

        at_check = m_busy && (cyc == m_req_cyc + int'(RESP_LAT));
        card     = at_check ? next_card() : int'($urandom_range(0, 255));
        card_i   = 8'(card);

        occ = m_fifo.size();
        if (occ != 0 && card_ready_i) void'(m_fifo.pop_front());
        idle_apply = !m_busy && m_pend;
        if (!m_busy) begin
            if (m_pend) begin
                for (int i = 0; i < 52; i++) m_deck[i] = 1'b0;
                m_fifo.delete();
                m_dealt = 0;
                m_stall = 1'b0;
                m_retry = 0;
                m_pend  = 1'b0;
            end else if (enable_i && !m_stall && m_dealt < 52 && occ < int'(FIFO_DEPTH)) begin
                m_busy    = 1'b1;
                m_req_cyc = cyc + 1;
            end
        end else if (at_check) begin
            bit ok;
            ok = 1'b0;
            if (card < 52) ok = !m_deck[card];
            if (ok) begin
                m_deck[card] = 1'b1;
                m_fifo.push_back(card);
                m_dealt++;
                m_retry = 0;
                m_busy  = 1'b0;
            end else begin
                m_retry++;
                if (m_retry == int'(MAX_RETRY)) begin
                    m_stall = 1'b1;
                    m_retry = 0;
                    m_busy  = 1'b0;
                end else begin
                    m_req_cyc = cyc + 1;
                end
            end
        end
        if (shuffle_i && !idle_apply) m_pend = 1'b1;

        @(negedge clk_i);
        cyc++;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        rst_i     = 1'b1;
        shuffle_i = 1'b0;
        card_i    = 8'($urandom_range(0, 255));
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        model_reset();
    endtask

    task automatic pulse_shuffle();
        shuffle_i = 1'b1;
        step();
        shuffle_i = 1'b0;
    endtask

    int base;

    initial begin
        enable_i     = 1'b0;
        shuffle_i    = 1'b0;
        card_ready_i = 1'b0;
        card_i       = 8'd0;
        rst_i        = 1'b1;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        model_reset();

        // Reset state: every output low.
        check_eq("rst request_card_o", 32'(request_card_o), 0);
        check_eq("rst card_o", 32'(card_o), 0);
        check_eq("rst card_valid_o", 32'(card_valid_o), 0);
        check_eq("rst dealt_cnt_o", 32'(dealt_cnt_o), 0);
        check_eq("rst deck_empty_o", 32'(deck_empty_o), 0);
        check_eq("rst stall_err_o", 32'(stall_err_o), 0);

        // 1: single accepted card.
        resp_q = '{17};
        base = n_req;
        enable_i = 1'b1;
        step();
        enable_i = 1'b0;
        steps(6);
        check_eq("t1 requests", 32'(n_req - base), 1);
        check_eq("t1 card_o", 32'(card_o), 17);
        check_eq("t1 dealt", 32'(dealt_cnt_o), 1);

        // 2: duplicate rejected, immediate re-request.
        resp_q = '{17, 23};
        base = n_req;
        enable_i = 1'b1;
        step();
        enable_i = 1'b0;
        steps(8);
        check_eq("t2 requests", 32'(n_req - base), 2);
        check_eq("t2 dealt", 32'(dealt_cnt_o), 2);

        // 3: stall after MAX_RETRY rejects, cleared by shuffle.
        resp_q.delete();
        for (int i = 0; i < int'(MAX_RETRY); i++) resp_q.push_back(60);
        base = n_req;
        enable_i = 1'b1;
        steps(60);
        check_eq("t3 requests", 32'(n_req - base), MAX_RETRY);
        check_eq("t3 stall", 32'(stall_err_o), 1);
        pulse_shuffle();
        base = n_req;
        steps(12);
        check_eq("t3 stall cleared", 32'(stall_err_o), 0);
        check_eq("t3 resumed", 32'(n_req > base), 1);
        enable_i = 1'b0;
        steps(10);

        // 4: FIFO fills with no consumer, one pop allows one more request.
        pulse_shuffle();
        steps(4);
        resp_q = '{40, 41, 42, 43};
        base = n_req;
        enable_i = 1'b1;
        steps(30);
        check_eq("t4 requests", 32'(n_req - base), 4);
        check_eq("t4 head", 32'(card_o), 40);
        resp_q = '{44};
        base = n_req;
        card_ready_i = 1'b1;
        step();
        card_ready_i = 1'b0;
        steps(10);
        check_eq("t4 refill requests", 32'(n_req - base), 1);
        check_eq("t4 head after pop", 32'(card_o), 41);

        // 5: deal the whole deck in order.
        enable_i = 1'b0;
        pulse_shuffle();
        steps(4);
        resp_q.delete();
        for (int i = 0; i < 52; i++) resp_q.push_back(i);
        base = n_req;
        card_ready_i = 1'b1;
        enable_i = 1'b1;
        steps(52 * 4 + 20);
        check_eq("t5 requests", 32'(n_req - base), 52);
        check_eq("t5 dealt", 32'(dealt_cnt_o), 52);
        check_eq("t5 deck_empty", 32'(deck_empty_o), 1);
        base = n_req;
        steps(10);
        check_eq("t5 halted", 32'(n_req - base), 0);
        pulse_shuffle();
        step();
        check_eq("t5 dealt after shuffle", 32'(dealt_cnt_o), 0);
        check_eq("t5 fifo flushed", 32'(card_valid_o), 0);
        base = n_req;
        steps(20);
        check_eq("t5 resumed", 32'(n_req > base), 1);

        // 6: shuffle during WAIT, applied after the in-flight card lands.
        enable_i     = 1'b0;
        card_ready_i = 1'b0;
        steps(10);
        pulse_shuffle();
        steps(3);
        resp_q = '{5};
        enable_i = 1'b1;
        step();
        enable_i = 1'b0;
        step();
        pulse_shuffle();
        steps(6);
        check_eq("t6 dealt after shuffle", 32'(dealt_cnt_o), 0);
        check_eq("t6 fifo flushed", 32'(card_valid_o), 0);
        resp_q = '{5};
        enable_i = 1'b1;
        step();
        enable_i = 1'b0;
        steps(6);
        check_eq("t6 card 5 again", 32'(card_o), 5);
        check_eq("t6 dealt", 32'(dealt_cnt_o), 1);

        // Random traffic with occasional shuffles and mid-run resets.
        for (int i = 0; i < 3000; i++) begin
            enable_i     = ($urandom_range(0, 9) != 0);
            card_ready_i = 1'($urandom_range(0, 1));
            shuffle_i    = ($urandom_range(0, 99) == 0);
            if (i % 700 == 699) begin
                do_reset();
            end else begin
                step();
            end
        end
        shuffle_i = 1'b0;
        enable_i  = 1'b0;
        steps(10);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
